rib_arbiter: RTL
================

// Module: rib_arbiter
// PURPOSE
//  Registered 4-master arbiter for the RIB bus, replacing the fixed combinational priority.
//  Masters: m0 core ex/mem, m1 core fetch, m2 jtag, m3 uart_debug.
//  Supports fixed-priority and round-robin modes, burst lock with a bounded tenure, and core hold.
//  Sits between the masters' req lines and the RIB address/data mux; gnt_id_o drives the mux select.
// PARAMETERS
//  NUM_M     4   number of masters; fixed at 4 for this revision, grant id is 2 bits
//  MAX_HOLD  8   max consecutive cycles one master may keep a locked grant while others wait (2..255)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  asynchronous reset, active-high
//  mode_i       in   1  0 = fixed priority m3>m2>m0>m1; 1 = round-robin
//  req_i        in   4  per-master request, level, held until served
//  lock_i       in   4  per-master burst lock, qualified by the matching req_i bit
//  gnt_o        out  4  one-hot registered grant; all-zero when idle
//  gnt_id_o     out  2  encoded index of the granted master; 0 when idle
//  gnt_valid_o  out  1  |gnt_o
//  hold_o       out  1  core stall: gnt_valid_o && gnt_id_o>=2 && (req_i[0]|req_i[1])
//  preempt_o    out  1  one-cycle pulse when a locked grant is revoked by MAX_HOLD expiry
// BEHAVIOUR
//  Reset: gnt_o=0, gnt_id_o=0, gnt_valid_o=0, preempt_o=0, rr_ptr=0, hold_cnt=0, state=IDLE.
//   hold_o is 0 during reset because gnt_valid_o=0.
//  States: IDLE (no grant) and OWN (one master granted).
//  Latency: a request seen at edge N is granted at edge N+1. gnt_o never has more than one bit set.
//  IDLE: if any req_i is set, pick a winner, go to OWN, set hold_cnt=1.
//  OWN, owner's req deasserts:
//   - If other reqs are pending, grant the next winner on the same edge (no idle bubble).
//   - Otherwise go to IDLE.
//  OWN, owner's req set, lock clear: rearbitrate every cycle.
//   - The owner competes normally and keeps the grant if it wins.
//  OWN, owner's req and lock set: keep the grant; hold_cnt increments, saturating at MAX_HOLD.
//   - When hold_cnt==MAX_HOLD and another req is pending: the owner is excluded,
//     the next winner is granted, and preempt_o pulses for one cycle.
//   - If no other req is pending, the owner keeps the grant indefinitely.
//  hold_cnt resets to 1 on every change of owner.
//  Fixed mode: winner is the highest of m3, m2, m0, m1 that is requesting.
//  RR mode: search starts at (rr_ptr) and goes upward modulo 4.
//   - rr_ptr <= winner+1 (wraps 3->0) on each new grant.
//   - rr_ptr is not updated by a grant retained under lock.
//  mode_i change takes effect at the next arbitration decision; the current owner is not disturbed.
//  A request that drops before being granted is simply lost; no queueing.
//  Simultaneous owner release plus new requests: the new winner is chosen among non-owner requesters.
//  Reset mid-operation: immediate return to reset values, no handshake completion.
// STRUCTURE
//  Shared defines file: RIB_M0..RIB_M3 indices, ARB_MODE_FIXED/ARB_MODE_RR, state encodings.
//  One sub-module, rib_arb_pick: combinational winner select.
//   - Inputs: req mask, mode, rr_ptr, exclude mask. Outputs: one-hot and index.
//   - Top holds the FSM, hold_cnt, rr_ptr and output registers.
// TESTING
//  Reset then req_i=4'b1111, fixed mode: next edge gnt_o=4'b1000, gnt_id_o=3, hold_o=1.
//  RR mode, req_i=4'b1111 held, lock=0: grants go m0,m1,m2,m3,m0, each lasting 1 cycle, rr_ptr wraps.
//  MAX_HOLD=8, m2 locked, m0 requesting: m2 held exactly 8 cycles, then gnt_o=4'b0001 with preempt_o=1 for 1 cycle.
//  m2 locked alone for 20 cycles: grant kept, preempt_o stays 0, hold_cnt saturates at 8.
//  m0 owner drops req while m1 requests: gnt_o goes 0001->0010 in one edge, with no idle cycle.
//  Assert rst mid-grant with m3 locked: gnt_o=0 immediately; after release, fixed-mode winner is re-chosen from current reqs.

Source files
------------

// File: rtl/rib_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rib_arbiter_pkg
//   Shared definitions for the RIB bus arbiter.
//   - RIB_M0..RIB_M3 : master indices (m0 core ex/mem, m1 core fetch,
//                      m2 jtag, m3 uart_debug)
//   - ARB_MODE_*     : encodings of the mode_i select
//   - arb_state_e    : arbiter FSM state encoding
//   - rr_next        : round-robin pointer successor (wraps 3 -> 0)
// ----------------------------------------------------------------------------
package rib_arbiter_pkg;

  localparam logic [1:0] RIB_M0 = 2'd0;
  localparam logic [1:0] RIB_M1 = 2'd1;
  localparam logic [1:0] RIB_M2 = 2'd2;
  localparam logic [1:0] RIB_M3 = 2'd3;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Round-robin search restarts just above the master that was last granted.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// ----------------------------------------------------------------------------
// rib_arb_pick
//   Combinational winner select for the RIB arbiter.
//   Ports:
//     req_i     [3:0] per-master request mask
//     mode_i          ARB_MODE_FIXED (m3>m2>m0>m1) or ARB_MODE_RR
//     rr_ptr_i  [1:0] round-robin search start index
//     excl_i    [3:0] masters removed from this decision
//     onehot_o  [3:0] one-hot winner, zero when no candidate
//     idx_o     [1:0] encoded winner, zero when no candidate
//     any_o           at least one candidate present
// ----------------------------------------------------------------------------
module rib_arb_pick
  import rib_arbiter_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic       mode_i,
  input  logic [1:0] rr_ptr_i,
  input  logic [3:0] excl_i,
  output logic [3:0] onehot_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [3:0] cand;
  logic [7:0] cand_dbl;
  logic [3:0] cand_rot;
  logic [1:0] rr_off;

  always_comb begin
    cand     = req_i & ~excl_i;
    any_o    = |cand;
    // Rotate so bit 0 is the master at rr_ptr; the lowest set bit of the
    // rotated vector is then the first requester found searching upward.
    cand_dbl = {cand, cand};
    cand_rot = cand_dbl[rr_ptr_i +: 4];
    casez (cand_rot)
      4'b???1: rr_off = 2'd0;
      4'b??10: rr_off = 2'd1;
      4'b?100: rr_off = 2'd2;
      4'b1000: rr_off = 2'd3;
      default: rr_off = 2'd0;
    endcase

    idx_o = 2'd0;
    case (mode_i)
      ARB_MODE_FIXED: begin
        if (cand[RIB_M3])      idx_o = RIB_M3;
        else if (cand[RIB_M2]) idx_o = RIB_M2;
        else if (cand[RIB_M0]) idx_o = RIB_M0;
        else if (cand[RIB_M1]) idx_o = RIB_M1;
        else                   idx_o = 2'd0;
      end
      ARB_MODE_RR: begin
        idx_o = rr_ptr_i + rr_off;
      end
    endcase

    onehot_o = any_o ? (4'b0001 << idx_o) : 4'b0000;
  end

endmodule

// File: rtl/rib_arbiter.sv
// ----------------------------------------------------------------------------
// rib_arbiter
//   Registered 4-master arbiter for the RIB bus with fixed-priority and
//   round-robin modes, burst lock with bounded tenure and core hold.
//   Ports:
//     clk          system clock
//     rst          asynchronous reset, active-high
//     mode_i       0 = fixed priority m3>m2>m0>m1, 1 = round-robin
//     req_i  [3:0] per-master level request
//     lock_i [3:0] per-master burst lock (qualified by req_i)
//     gnt_o  [3:0] one-hot registered grant, zero when idle
//     gnt_id_o [1:0] encoded grant index (mux select), zero when idle
//     gnt_valid_o  any grant active
//     hold_o       core stall while jtag/uart owns the bus and a core requests
//     preempt_o    one-cycle pulse when a locked grant is revoked by tenure expiry
// ----------------------------------------------------------------------------
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] lock_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [1:0]       gnt_id_o,
  output logic             gnt_valid_o,
  output logic             hold_o,
  output logic             preempt_o
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             preempt_q, preempt_d;

  logic [3:0]       pick_excl;
  logic [3:0]       pick_onehot;
  logic [1:0]       pick_idx;
  logic             pick_any;

  logic             owner_req;
  logic             owner_lock;
  logic             others_req;
  logic             take_new;

  rib_arb_pick u_pick (
    .req_i    (req_i),
    .mode_i   (mode_i),
    .rr_ptr_i (rr_ptr_q),
    .excl_i   (pick_excl),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    preempt_d  = 1'b0;
    pick_excl  = 4'b0000;
    take_new   = 1'b0;

    owner_req  = |(req_i & gnt_q);
    owner_lock = |(lock_i & gnt_q);
    others_req = |(req_i & ~gnt_q);

    case (state_q)
      ST_IDLE: begin
        take_new = pick_any;
      end
      ST_OWN: begin
        if (!owner_req) begin
          // Owner released: hand over on the same edge if anyone else waits.
          pick_excl = gnt_q;
          if (pick_any) begin
            take_new = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            gnt_d      = '0;
            gnt_id_d   = 2'd0;
            hold_cnt_d = 8'd0;
          end
        end else if (!owner_lock) begin
          // Unlocked owner competes with everyone; the pick always succeeds.
          take_new = 1'b1;
        end else if ((hold_cnt_q == MAX_HOLD_C) && others_req) begin
          // Tenure exhausted with competition: revoke and pass the bus on.
          pick_excl = gnt_q;
          take_new  = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_cnt_q != MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every arbitration decision counts as a fresh grant, including an
    // unlocked owner winning again, so tenure only accumulates under lock.
    if (take_new) begin
      state_d    = ST_OWN;
      gnt_d      = pick_onehot;
      gnt_id_d   = pick_idx;
      hold_cnt_d = 8'd1;
      rr_ptr_d   = rr_next(pick_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= 2'd0;
      hold_cnt_q <= 8'd0;
      rr_ptr_q   <= 2'd0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = |gnt_q;
  assign preempt_o   = preempt_q;
  // Debug masters (id 2/3) own the bus while a core master is asking.
  assign hold_o      = gnt_valid_o && gnt_id_q[1] && (req_i[RIB_M0] | req_i[RIB_M1]);

endmodule
